// File: rtl/oven_bake_controller_if.sv
// Interface: oven_bake_controller_if
// Groups the bake controller's control, sensor and status signals.
//   master : button/setpoint logic and temperature sensor side (drives requests, reads status)
//   slave  : oven_bake_controller (reads requests, drives status)
// Signals:
//   tick_1hz, start, cancel        one-clk pulses into the controller
//   target_temp, bake_secs         setpoint and bake time, sampled on accepted start
//   cur_temp                       present oven temperature
//   heater_on, state, time_left    heater enable, state code, seconds remaining
//   preheated, done, fault, err    status flags / start-rejected pulse
//   door_open                      only when OVEN_DOOR_INTERLOCK_EN is defined
interface oven_bake_controller_if #(
    parameter int unsigned TEMP_W = 11,
    parameter int unsigned TIME_W = 17
);
    logic              tick_1hz;
    logic              start;
    logic              cancel;
    logic [TEMP_W-1:0] target_temp;
    logic [TIME_W-1:0] bake_secs;
    logic [TEMP_W-1:0] cur_temp;
`ifdef OVEN_DOOR_INTERLOCK_EN
    logic              door_open;
`endif
    logic              heater_on;
    logic [2:0]        state;
    logic [TIME_W-1:0] time_left;
    logic              preheated;
    logic              done;
    logic              fault;
    logic              err;

    modport master (
`ifdef OVEN_DOOR_INTERLOCK_EN
        output door_open,
`endif
        output tick_1hz, start, cancel, target_temp, bake_secs, cur_temp,
        input  heater_on, state, time_left, preheated, done, fault, err
    );

    modport slave (
`ifdef OVEN_DOOR_INTERLOCK_EN
        input  door_open,
`endif
        input  tick_1hz, start, cancel, target_temp, bake_secs, cur_temp,
        output heater_on, state, time_left, preheated, done, fault, err
    );
endinterface

// File: rtl/oven_bake_controller.sv
// Module: oven_bake_controller
// Sequences one oven bake cycle: latch setpoint and bake time, preheat, hold temperature with a
// hysteresis band, count the bake time down on tick_1hz, then raise done for DONE_HOLD_S seconds.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    oven_bake_controller_if.slave (requests in, heater/status out)
// Configuration macro: OVEN_DOOR_INTERLOCK_EN adds bus.door_open; while the door is open in
// PREHEAT/BAKE the heater is off and the bake timer is frozen, and a start in IDLE is rejected.
// Every output is registered. State codes: 0 IDLE, 1 PREHEAT, 2 BAKE, 3 DONE, 4 FAULT.
module oven_bake_controller #(
    parameter int unsigned TEMP_W      = 11,
    parameter int unsigned TIME_W      = 17,
    parameter int unsigned HYST        = 2,
    parameter int unsigned MAX_TEMP    = 500,
    parameter int unsigned DONE_HOLD_S = 5
) (
    input logic                   clk,
    input logic                   rst_n,
    oven_bake_controller_if.slave bus
);

    localparam int unsigned HOLD_W = (DONE_HOLD_S < 2) ? 1 : $clog2(DONE_HOLD_S + 1);

    localparam logic [TEMP_W-1:0] MaxTemp  = TEMP_W'(MAX_TEMP);
    localparam logic [TEMP_W-1:0] HystVal  = TEMP_W'(HYST);
    localparam logic [HOLD_W-1:0] HoldLast = HOLD_W'((DONE_HOLD_S == 0) ? 0 : DONE_HOLD_S - 1);
    localparam logic [TIME_W-1:0] TimeOne  = TIME_W'(1);
    localparam logic [HOLD_W-1:0] HoldOne  = HOLD_W'(1);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StPreheat = 3'd1,
        StBake    = 3'd2,
        StDone    = 3'd3,
        StFault   = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic              heater_q, heater_d;
    logic [TIME_W-1:0] time_q, time_d;
    logic [TEMP_W-1:0] tgt_q, tgt_d;
    logic [TIME_W-1:0] secs_q, secs_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              err_q, err_d;
    logic              preheated_q, done_q, fault_q;

    logic              door_open;
    logic              start_ok;
    logic              over_temp;
    logic [TEMP_W-1:0] bake_lo;

`ifdef OVEN_DOOR_INTERLOCK_EN
    assign door_open = bus.door_open;
`else
    assign door_open = 1'b0;
`endif

    assign start_ok = (bus.target_temp != '0) && (bus.target_temp <= MaxTemp) &&
                      (bus.bake_secs != '0) && !door_open;

    assign over_temp = (bus.cur_temp > MaxTemp);

    // Lower edge of the hysteresis band, clamped at zero for tiny setpoints.
    assign bake_lo = (tgt_q > HystVal) ? (tgt_q - HystVal) : '0;

    always_comb begin
        state_d  = state_q;
        heater_d = heater_q;
        time_d   = time_q;
        tgt_d    = tgt_q;
        secs_d   = secs_q;
        hold_d   = '0;
        err_d    = 1'b0;

        if ((state_q != StFault) && over_temp) begin
            state_d  = StFault;
            heater_d = 1'b0;
            time_d   = '0;
        end else if (bus.cancel) begin
            // Also the only exit from FAULT.
            state_d  = StIdle;
            heater_d = 1'b0;
            time_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    heater_d = 1'b0;
                    time_d   = '0;
                    if (bus.start) begin
                        if (start_ok) begin
                            tgt_d    = bus.target_temp;
                            secs_d   = bus.bake_secs;
                            // Heater comes on together with PREHEAT when the oven is cold.
                            heater_d = (bus.cur_temp < bus.target_temp);
                            state_d  = StPreheat;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end

                StPreheat: begin
                    if (door_open) begin
                        heater_d = 1'b0;
                    end else if (bus.cur_temp >= tgt_q) begin
                        // A tick in this cycle is deliberately not applied to the timer.
                        state_d  = StBake;
                        time_d   = secs_q;
                        heater_d = 1'b0;
                    end else begin
                        heater_d = 1'b1;
                    end
                end

                StBake: begin
                    if (door_open) begin
                        heater_d = 1'b0;
                    end else begin
                        if (bus.cur_temp >= tgt_q) begin
                            heater_d = 1'b0;
                        end else if (bus.cur_temp < bake_lo) begin
                            heater_d = 1'b1;
                        end
                        if (bus.tick_1hz) begin
                            if (time_q <= TimeOne) begin
                                time_d   = '0;
                                heater_d = 1'b0;
                                state_d  = StDone;
                            end else begin
                                time_d = time_q - TimeOne;
                            end
                        end
                    end
                end

                StDone: begin
                    heater_d = 1'b0;
                    time_d   = '0;
                    hold_d   = hold_q;
                    if (bus.tick_1hz) begin
                        if (hold_q >= HoldLast) begin
                            hold_d  = '0;
                            state_d = StIdle;
                        end else begin
                            hold_d = hold_q + HoldOne;
                        end
                    end
                end

                StFault: begin
                    heater_d = 1'b0;
                    time_d   = '0;
                end

                default: begin
                    state_d  = StIdle;
                    heater_d = 1'b0;
                    time_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            heater_q    <= 1'b0;
            time_q      <= '0;
            tgt_q       <= '0;
            secs_q      <= '0;
            hold_q      <= '0;
            err_q       <= 1'b0;
            preheated_q <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            heater_q    <= heater_d;
            time_q      <= time_d;
            tgt_q       <= tgt_d;
            secs_q      <= secs_d;
            hold_q      <= hold_d;
            err_q       <= err_d;
            preheated_q <= (state_d == StBake);
            done_q      <= (state_d == StDone);
            fault_q     <= (state_d == StFault);
        end
    end

    assign bus.heater_on = heater_q;
    assign bus.state     = state_q;
    assign bus.time_left = time_q;
    assign bus.preheated = preheated_q;
    assign bus.done      = done_q;
    assign bus.fault     = fault_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_oven_bake_controller.sv
// Directed testbench for oven_bake_controller. Inputs change 1 ns after the rising edge and
// outputs are sampled at that same point, well away from the active edge.
module tb_oven_bake_controller;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #10 clk = ~clk;

    oven_bake_controller_if #(.TEMP_W(11), .TIME_W(17)) bus ();

    oven_bake_controller #(
        .TEMP_W      (11),
        .TIME_W      (17),
        .HYST        (2),
        .MAX_TEMP    (500),
        .DONE_HOLD_S (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_once();
        bus.tick_1hz = 1'b1;
        step();
        bus.tick_1hz = 1'b0;
    endtask

    task automatic do_cancel();
        bus.cancel = 1'b1;
        step();
        bus.cancel = 1'b0;
    endtask

    task automatic start_bake(input int tgt, input int secs);
        bus.target_temp = 11'(tgt);
        bus.bake_secs   = 17'(secs);
        bus.start       = 1'b1;
        step();
        bus.start       = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (bus.state !== 3'd0) begin
            errors++; $display("FAIL reset_state: got %0d expected 0", bus.state);
        end
        checks++;
        if (bus.heater_on !== 1'b0) begin
            errors++; $display("FAIL reset_heater: got %0b expected 0", bus.heater_on);
        end
        checks++;
        if (bus.time_left !== 17'd0) begin
            errors++; $display("FAIL reset_time_left: got %0d expected 0", bus.time_left);
        end
        checks++;
        if ({bus.preheated, bus.done, bus.fault, bus.err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {bus.preheated, bus.done, bus.fault, bus.err});
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset_mid_bake();
        bus.cur_temp = 11'd360;
        start_bake(357, 37);
        step();
        checks++;
        if (bus.state !== 3'd2 || bus.time_left !== 17'd37) begin
            errors++;
            $display("FAIL midrst_in_bake: got state %0d time %0d expected 2 37",
                     bus.state, bus.time_left);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.state !== 3'd0 || bus.time_left !== 17'd0) begin
            errors++;
            $display("FAIL midrst_async: got state %0d time %0d expected 0 0",
                     bus.state, bus.time_left);
        end
        checks++;
        if (bus.heater_on !== 1'b0 || bus.preheated !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outs: got heater %0b preheated %0b expected 0 0",
                     bus.heater_on, bus.preheated);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_bake_cycle();
        bus.cur_temp = 11'd300;
        start_bake(357, 3);
        checks++;
        if (bus.state !== 3'd1 || bus.heater_on !== 1'b1) begin
            errors++;
            $display("FAIL cycle_preheat: got state %0d heater %0b expected 1 1",
                     bus.state, bus.heater_on);
        end
        bus.cur_temp = 11'd330;
        step();
        checks++;
        if (bus.state !== 3'd1 || bus.heater_on !== 1'b1) begin
            errors++;
            $display("FAIL cycle_ramp: got state %0d heater %0b expected 1 1",
                     bus.state, bus.heater_on);
        end
        bus.cur_temp = 11'd357;
        step();
        checks++;
        if (bus.state !== 3'd2 || bus.time_left !== 17'd3 || bus.preheated !== 1'b1 ||
            bus.heater_on !== 1'b0) begin
            errors++;
            $display("FAIL cycle_bake_entry: got state %0d time %0d pre %0b heat %0b exp 2 3 1 0",
                     bus.state, bus.time_left, bus.preheated, bus.heater_on);
        end
        tick_once();
        checks++;
        if (bus.time_left !== 17'd2) begin
            errors++; $display("FAIL cycle_tick1: got %0d expected 2", bus.time_left);
        end
        tick_once();
        tick_once();
        checks++;
        if (bus.state !== 3'd3 || bus.done !== 1'b1 || bus.time_left !== 17'd0) begin
            errors++;
            $display("FAIL cycle_done: got state %0d done %0b time %0d expected 3 1 0",
                     bus.state, bus.done, bus.time_left);
        end
        for (int i = 0; i < 4; i++) tick_once();
        checks++;
        if (bus.state !== 3'd3) begin
            errors++; $display("FAIL cycle_hold4: got state %0d expected 3", bus.state);
        end
        tick_once();
        checks++;
        if (bus.state !== 3'd0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL cycle_hold5: got state %0d done %0b expected 0 0",
                     bus.state, bus.done);
        end
    endtask

    task automatic test_transition_tick();
        bus.cur_temp = 11'd357;
        start_bake(357, 3);
        tick_once();
        checks++;
        if (bus.state !== 3'd2 || bus.time_left !== 17'd3) begin
            errors++;
            $display("FAIL trans_tick: got state %0d time %0d expected 2 3",
                     bus.state, bus.time_left);
        end
        do_cancel();
    endtask

    task automatic test_hysteresis();
        int   temps [5] = '{357, 356, 354, 356, 357};
        logic exp_h [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        bus.cur_temp = 11'd357;
        start_bake(357, 100);
        step();
        checks++;
        if (bus.state !== 3'd2 || bus.time_left !== 17'd100) begin
            errors++;
            $display("FAIL hyst_entry: got state %0d time %0d expected 2 100",
                     bus.state, bus.time_left);
        end
        for (int i = 0; i < 5; i++) begin
            bus.cur_temp = 11'(temps[i]);
            step();
            checks++;
            if (bus.heater_on !== exp_h[i]) begin
                errors++;
                $display("FAIL hyst_heater[%0d] temp %0d: got %0b expected %0b",
                         i, temps[i], bus.heater_on, exp_h[i]);
            end
        end
        do_cancel();
        checks++;
        if (bus.state !== 3'd0 || bus.time_left !== 17'd0) begin
            errors++;
            $display("FAIL hyst_cancel: got state %0d time %0d expected 0 0",
                     bus.state, bus.time_left);
        end
    endtask

    task automatic test_invalid_start();
        int tgts [3] = '{0, 501, 357};
        int secs [3] = '{10, 10, 0};
        bus.cur_temp = 11'd300;
        for (int i = 0; i < 3; i++) begin
            start_bake(tgts[i], secs[i]);
            checks++;
            if (bus.err !== 1'b1 || bus.state !== 3'd0) begin
                errors++;
                $display("FAIL invalid_err[%0d]: got err %0b state %0d expected 1 0",
                         i, bus.err, bus.state);
            end
            step();
            checks++;
            if (bus.err !== 1'b0) begin
                errors++; $display("FAIL invalid_pulse[%0d]: got err %0b expected 0", i, bus.err);
            end
        end
        start_bake(500, 10);
        checks++;
        if (bus.state !== 3'd1 || bus.err !== 1'b0 || bus.heater_on !== 1'b1) begin
            errors++;
            $display("FAIL max_target: got state %0d err %0b heat %0b expected 1 0 1",
                     bus.state, bus.err, bus.heater_on);
        end
        do_cancel();
        checks++;
        if (bus.state !== 3'd0 || bus.heater_on !== 1'b0) begin
            errors++;
            $display("FAIL preheat_cancel: got state %0d heat %0b expected 0 0",
                     bus.state, bus.heater_on);
        end
    endtask

    task automatic test_fault();
        bus.cur_temp = 11'd357;
        start_bake(357, 50);
        step();
        bus.cur_temp = 11'd500;
        step();
        checks++;
        if (bus.state !== 3'd2 || bus.fault !== 1'b0) begin
            errors++;
            $display("FAIL fault_at_max: got state %0d fault %0b expected 2 0",
                     bus.state, bus.fault);
        end
        bus.cur_temp = 11'd501;
        step();
        checks++;
        if (bus.state !== 3'd4 || bus.fault !== 1'b1 || bus.heater_on !== 1'b0 ||
            bus.time_left !== 17'd0) begin
            errors++;
            $display("FAIL fault_entry: got state %0d fault %0b heat %0b time %0d exp 4 1 0 0",
                     bus.state, bus.fault, bus.heater_on, bus.time_left);
        end
        bus.cur_temp = 11'd300;
        start_bake(357, 10);
        checks++;
        if (bus.state !== 3'd4 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL fault_start: got state %0d err %0b expected 4 0", bus.state, bus.err);
        end
        do_cancel();
        checks++;
        if (bus.state !== 3'd0 || bus.fault !== 1'b0) begin
            errors++;
            $display("FAIL fault_cancel: got state %0d fault %0b expected 0 0",
                     bus.state, bus.fault);
        end
    endtask

    task automatic test_cancel_priority();
        bus.cur_temp    = 11'd300;
        bus.target_temp = 11'd357;
        bus.bake_secs   = 17'd10;
        bus.start       = 1'b1;
        bus.cancel      = 1'b1;
        step();
        bus.start       = 1'b0;
        bus.cancel      = 1'b0;
        checks++;
        if (bus.state !== 3'd0 || bus.err !== 1'b0 || bus.heater_on !== 1'b0) begin
            errors++;
            $display("FAIL cancel_beats_start: got state %0d err %0b heat %0b expected 0 0 0",
                     bus.state, bus.err, bus.heater_on);
        end
        bus.cur_temp = 11'd357;
        start_bake(357, 1);
        step();
        checks++;
        if (bus.state !== 3'd2 || bus.time_left !== 17'd1) begin
            errors++;
            $display("FAIL cancel_setup: got state %0d time %0d expected 2 1",
                     bus.state, bus.time_left);
        end
        bus.cancel   = 1'b1;
        bus.tick_1hz = 1'b1;
        step();
        bus.cancel   = 1'b0;
        bus.tick_1hz = 1'b0;
        checks++;
        if (bus.state !== 3'd0 || bus.done !== 1'b0 || bus.time_left !== 17'd0) begin
            errors++;
            $display("FAIL cancel_beats_tick: got state %0d done %0b time %0d expected 0 0 0",
                     bus.state, bus.done, bus.time_left);
        end
    endtask

`ifdef OVEN_DOOR_INTERLOCK_EN
    task automatic test_door();
        bus.cur_temp  = 11'd357;
        start_bake(357, 10);
        step();
        bus.cur_temp  = 11'd350;
        bus.door_open = 1'b1;
        for (int i = 0; i < 4; i++) tick_once();
        checks++;
        if (bus.state !== 3'd2 || bus.time_left !== 17'd10 || bus.heater_on !== 1'b0) begin
            errors++;
            $display("FAIL door_frozen: got state %0d time %0d heat %0b expected 2 10 0",
                     bus.state, bus.time_left, bus.heater_on);
        end
        bus.door_open = 1'b0;
        step();
        checks++;
        if (bus.heater_on !== 1'b1) begin
            errors++; $display("FAIL door_resume: got heat %0b expected 1", bus.heater_on);
        end
        do_cancel();
        bus.door_open = 1'b1;
        start_bake(357, 10);
        checks++;
        if (bus.err !== 1'b1 || bus.state !== 3'd0) begin
            errors++;
            $display("FAIL door_start: got err %0b state %0d expected 1 0", bus.err, bus.state);
        end
        bus.door_open = 1'b0;
        step();
    endtask
`endif

    initial begin
        bus.tick_1hz    = 1'b0;
        bus.start       = 1'b0;
        bus.cancel      = 1'b0;
        bus.target_temp = '0;
        bus.bake_secs   = '0;
        bus.cur_temp    = 11'd300;
`ifdef OVEN_DOOR_INTERLOCK_EN
        bus.door_open   = 1'b0;
`endif
        test_reset();
        test_reset_mid_bake();
        test_bake_cycle();
        test_transition_tick();
        test_hysteresis();
        test_invalid_start();
        test_fault();
        test_cancel_priority();
`ifdef OVEN_DOOR_INTERLOCK_EN
        test_door();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
